muldiv_unit: RTL and testbench

- Iterative multiply/divide engine with HI/LO result registers for the next-generation pipelined CPU. Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in EX. Takes operands from the ID/EX pipeline register.
- Reports busy so the hazard logic can stall MFHI/MFLO and further mul/div ops. Supports flush on branch squash.
- Generalised in operand width, and in multiply bits per cycle.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_divider_core.sv | 58 +++++
 rtl/muldiv_unit.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit: op encoding, FSM states and
// small decode helpers used by the top and the divide datapath.
package muldiv_pkg;

    // Operation path selector driven from the ID/EX register.
    typedef logic [2:0] md_op_t;

    localparam md_op_t MD_MULT  = 3'd0;
    localparam md_op_t MD_MULTU = 3'd1;
    localparam md_op_t MD_DIV   = 3'd2;
    localparam md_op_t MD_DIVU  = 3'd3;
    localparam md_op_t MD_MTHI  = 3'd4;
    localparam md_op_t MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_CALC  = 2'd1,
        MD_FIXUP = 2'd2
    } md_state_e;

    // MULT/MULTU/DIV/DIVU: the ops that run through CALC and FIXUP.
    function automatic logic md_is_arith(input md_op_t op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic md_is_mul(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic md_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_divider_core.sv
// Restoring unsigned divider: one quotient bit per step. The dividend is
// shifted out of the quotient register into the partial remainder while the
// quotient bits are shifted in behind it.
module muldiv_divider_core
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    logic [W-1:0] r_rem;
    logic [W-1:0] r_quo;
    logic [W-1:0] r_dsr;

    logic [W:0]   w_trial;
    logic [W:0]   w_diff;
    logic         w_fits;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        w_trial = {r_rem, r_quo[W-1]};
        w_diff  = w_trial - {1'b0, r_dsr};
        w_fits  = (w_trial >= {1'b0, r_dsr});
    end

    // Remainder/quotient shift registers; both results fit in W bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dsr <= '0;
        end else if (load) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_dsr <= divisor;
        end else if (step) begin
            if (w_fits) begin
                r_rem <= w_diff[W-1:0];
                r_quo <= {r_quo[W-2:0], 1'b1};
            end else begin
                r_rem <= w_trial[W-1:0];
                r_quo <= {r_quo[W-2:0], 1'b0};
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine with HI/LO registers. Operands are made
// unsigned on issue, iterated in CALC, and sign-corrected in FIXUP where
// HI/LO are written.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    // Multiplier bits retired per CALC cycle (1 or 2); must divide DATA_WIDTH.
    parameter int MUL_RADIX_LOG2 = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] srcA,
    input  logic [DATA_WIDTH-1:0] srcB,
    input  logic                  flush,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W        = DATA_WIDTH;
    localparam int MUL_BITS = MUL_RADIX_LOG2;
    localparam int CW       = $clog2(W + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(W / MUL_BITS);
    localparam logic [CW-1:0] DIV_CNT = CW'(W);

    md_state_e       r_state;
    md_state_e       w_state_next;

    logic [CW-1:0]   r_count;
    logic [2*W-1:0]  r_acc;      // {partial product, remaining multiplier bits}
    logic [W-1:0]    r_mcand;
    logic            r_is_mul;
    logic            r_neg_res;
    logic            r_neg_rem;
    logic            r_divzero;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic            r_done;

    logic            w_accept;
    logic            w_arith;
    logic            w_signed;
    logic [W-1:0]    w_abs_a;
    logic [W-1:0]    w_abs_b;
    logic            w_div_load;
    logic            w_div_step;
    logic [W-1:0]    w_quo;
    logic [W-1:0]    w_rem;

    logic [W+MUL_BITS-1:0] w_pp [MUL_BITS];
    logic [W+MUL_BITS-1:0] w_partial;
    logic [W+MUL_BITS-1:0] w_sum;
    logic [2*W-1:0]        w_acc_next;

    logic [2*W-1:0]  w_prod_fix;
    logic [W-1:0]    w_quo_fix;
    logic [W-1:0]    w_rem_fix;

    // Issue decode and operand magnitude for signed ops.
    always_comb begin
        w_accept = start && (r_state == MD_IDLE) && !flush;
        w_arith  = md_is_arith(op);
        w_signed = md_is_signed(op);
        w_abs_a  = (w_signed && srcA[W-1]) ? -srcA : srcA;
        w_abs_b  = (w_signed && srcB[W-1]) ? -srcB : srcB;
    end

    assign w_div_load = w_accept && w_arith && !md_is_mul(op);
    assign w_div_step = (r_state == MD_CALC) && !r_is_mul && !flush;

    muldiv_divider_core #(
        .W (W)
    ) u_divider_core (
        .clk       (clk),
        .rst       (rst),
        .load      (w_div_load),
        .step      (w_div_step),
        .dividend  (w_abs_a),
        .divisor   (w_abs_b),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // One shifted copy of the multiplicand per multiplier bit retired this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < MUL_BITS; gi++) begin : g_pp
            assign w_pp[gi] = r_acc[gi] ? ((W+MUL_BITS)'(r_mcand) << gi) : '0;
        end
    endgenerate

    // Shift-add step: add partial products to the upper half, shift right.
    always_comb begin
        w_partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            w_partial = w_partial + w_pp[i];
        end
        w_sum      = {{MUL_BITS{1'b0}}, r_acc[2*W-1:W]} + w_partial;
        w_acc_next = {w_sum, r_acc[W-1:MUL_BITS]};
    end

    // Sign correction; divide by zero forces an all-ones quotient.
    always_comb begin
        w_prod_fix = r_neg_res ? -r_acc : r_acc;
        w_quo_fix  = r_divzero ? '1 : (r_neg_res ? -w_quo : w_quo);
        w_rem_fix  = r_neg_rem ? -w_rem : w_rem;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: flush abandons CALC/FIXUP without touching HI/LO.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            MD_IDLE: begin
                if (w_accept && w_arith) begin
                    w_state_next = MD_CALC;
                end
            end
            MD_CALC: begin
                if (flush) begin
                    w_state_next = MD_IDLE;
                end else if (r_count == CW'(1)) begin
                    w_state_next = MD_FIXUP;
                end
            end
            MD_FIXUP: begin
                w_state_next = MD_IDLE;
            end
            default: begin
                w_state_next = MD_IDLE;
            end
        endcase
    end

    // Datapath: operand latch on issue, iteration in CALC, HI/LO write in FIXUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_is_mul  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        if (op == MD_MTHI) begin
                            r_hi <= srcA;
                        end else if (op == MD_MTLO) begin
                            r_lo <= srcA;
                        end else if (w_arith) begin
                            r_is_mul  <= md_is_mul(op);
                            r_count   <= md_is_mul(op) ? MUL_CNT : DIV_CNT;
                            r_neg_res <= w_signed && (srcA[W-1] ^ srcB[W-1]);
                            r_neg_rem <= w_signed && srcA[W-1];
                            r_divzero <= (srcB == '0);
                            r_mcand   <= w_abs_a;
                            r_acc     <= {{W{1'b0}}, w_abs_b};
                        end
                    end
                end
                MD_CALC: begin
                    if (!flush) begin
                        r_count <= r_count - CW'(1);
                        if (r_is_mul) begin
                            r_acc <= w_acc_next;
                        end
                    end
                end
                MD_FIXUP: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_is_mul) begin
                            r_hi <= w_prod_fix[2*W-1:W];
                            r_lo <= w_prod_fix[W-1:0];
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (r_state == MD_IDLE);
    assign busy  = ~ready;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: one instance at 1 multiplier bit/cycle and
// one at 2 bits/cycle, driven by the same stimulus.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        flush;

    logic        ready, busy, done;
    logic [31:0] hi, lo;
    logic        ready2, busy2, done2;
    logic [31:0] hi2, lo2;

    int n_cmp = 0;
    int n_bad = 0;
    int lat1, lat2, dn1, dn2;
    int done_seen = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(32), .MUL_RADIX_LOG2(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .flush(flush), .ready(ready), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.DATA_WIDTH(32), .MUL_RADIX_LOG2(2)) u_dut_r2 (
        .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .flush(flush), .ready(ready2), .busy(busy2), .done(done2), .hi(hi2), .lo(lo2)
    );

    // Running count of done pulses on the radix-1 instance.
    always @(posedge clk) begin
        if (done) done_seen++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, then sample on every falling edge until both instances are
    // idle. Optionally inject a DIVU start at iteration inj (while busy).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj);
        int g;
        @(negedge clk);
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0;
        lat1 = 0; lat2 = 0; dn1 = 0; dn2 = 0;
        for (g = 0; g < 200; g++) begin
            if (done)  dn1++;
            if (done2) dn2++;
            if (busy)  lat1++;
            if (busy2) lat2++;
            if (!busy && !busy2) break;
            if (inj > 0 && g == inj) begin
                start = 1'b1; op = MD_DIVU; srcA = 32'd100; srcB = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (g >= 200) check_val("timeout", {62'd0, busy, busy2}, 64'd0);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d/%0d done=%0d/%0d",
                 o, a, b, hi, lo, lat1, lat2, dn1, dn2);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; srcA = '0; srcB = '0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", ready, 1);
        check_val("rst_busy",  busy, 0);
        check_val("rst_done",  done, 0);
        check_val("rst_hilo",  {hi, lo}, 64'd0);
        rst = 1'b0;

        // MULTU max * max
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        check_val("multu_lat",  lat1, 33);
        check_val("multu_done", dn1, 1);
        check_val("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
        check_val("multu_r2_lat", lat2, 17);
        check_val("multu_r2_hilo", {hi2, lo2}, 64'hFFFFFFFE_00000001);

        // MULT -7 * 6
        run_op(MD_MULT, 32'hFFFFFFF9, 32'd6, 0);
        check_val("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);
        check_val("mult_r2_lat", lat2, 17);
        check_val("mult_r2_done", dn2, 1);
        check_val("mult_r2_hilo", {hi2, lo2}, 64'hFFFFFFFF_FFFFFFD6);

        // DIV -7 / 2
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 0);
        check_val("div_lat",  lat1, 33);
        check_val("div_done", dn1, 1);
        check_val("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        // DIVU 100 / 7
        run_op(MD_DIVU, 32'd100, 32'd7, 0);
        check_val("divu_hilo", {hi, lo}, {32'd2, 32'd14});

        // DIV MIN / -1 overflow
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        check_val("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

        // DIVU by zero
        run_op(MD_DIVU, 32'h1234, 32'd0, 0);
        check_val("divu0_lat",  lat1, 33);
        check_val("divu0_hilo", {hi, lo}, 64'h00001234_FFFFFFFF);

        // DIV negative by zero: hi keeps the signed dividend
        run_op(MD_DIV, 32'hFFFFFFF8, 32'd0, 0);
        check_val("div0_hilo", {hi, lo}, 64'hFFFFFFF8_FFFFFFFF);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        start = 1'b1; op = MD_MTHI; srcA = 32'hAAAA5555;
        @(negedge clk);
        check_val("mthi_hi", hi, 32'hAAAA5555);
        check_val("mthi_lo", lo, 32'hFFFFFFFF);
        check_val("mthi_ready", ready, 1);
        check_val("mthi_done", done, 0);
        op = MD_MTLO; srcA = 32'h0F0F0F0F;
        @(negedge clk);
        start = 1'b0;
        check_val("mtlo_hilo", {hi, lo}, 64'hAAAA5555_0F0F0F0F);
        check_val("mtlo_ready", ready, 1);
        check_val("mtlo_done", done, 0);
        $display("op=MTHI/MTLO -> hi=%h lo=%h", hi, lo);

        // MULTU 3*5 with a DIVU start injected while busy
        run_op(MD_MULTU, 32'd3, 32'd5, 5);
        check_val("busy_start_lat",  lat1, 33);
        check_val("busy_start_hilo", {hi, lo}, {32'd0, 32'd15});
        check_val("busy_start_r2_hilo", {hi2, lo2}, {32'd0, 32'd15});
        @(negedge clk);
        check_val("busy_start_idle", ready, 1);

        // MULT 100*7 flushed at cycle 10
        begin
            int d0;
            d0 = done_seen;
            @(negedge clk);
            start = 1'b1; op = MD_MULT; srcA = 32'd100; srcB = 32'd7;
            @(negedge clk);
            start = 1'b0;
            repeat (8) @(negedge clk);
            check_val("flush_busy_before", busy, 1);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            check_val("flush_ready", ready, 1);
            check_val("flush_r2_ready", ready2, 1);
            repeat (40) @(negedge clk);
            check_val("flush_hilo", {hi, lo}, {32'd0, 32'd15});
            check_val("flush_no_done", done_seen, d0);
            $display("op=MULT flushed -> hi=%h lo=%h", hi, lo);
        end

        // Start with flush in the same cycle is dropped (MTHI and MULT)
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = MD_MTHI; srcA = 32'h11111111;
        @(negedge clk);
        op = MD_MULT; srcA = 32'd9; srcB = 32'd9;
        check_val("flush_mthi_hi", hi, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check_val("flush_mult_ready", ready, 1);

        // Reserved op is ignored
        @(negedge clk);
        start = 1'b1; op = 3'd6; srcA = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        check_val("rsvd_ready", ready, 1);
        check_val("rsvd_hilo", {hi, lo}, {32'd0, 32'd15});

        // Reset mid-DIVU
        @(negedge clk);
        start = 1'b1; op = MD_DIVU; srcA = 32'd100; srcB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_ready", ready, 1);
        check_val("midrst_done", done, 0);
        check_val("midrst_hilo", {hi, lo}, 64'd0);
        repeat (40) @(negedge clk);
        check_val("midrst_hilo_later", {hi, lo}, 64'd0);
        $display("reset mid-DIVU -> hi=%h lo=%h ready=%0d", hi, lo, ready);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
